// File: rtl/alu_serial_rx.sv
// alu_serial_rx: assembles 11-bit serial packets (8 DATA + 1 CTL) into an ALU command with error flags.
// Define ALU_SERIAL_RX_CRC_CHECK_EN to include the 4-bit frame CRC check (otherwise err_crc is tied to 0).
module alu_serial_rx #(
  parameter int GAP_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [2:0]  op_out,
  output logic [2:0]  err_flags,
  output logic        frame_err
);
  // state   | meaning
  // IDLE    | waiting for start bit; gap timer runs while a frame is partial
  // TYPE    | sampling the type bit (0 = DATA, 1 = CTL)
  // PAYLOAD | shifting in 8 payload bits, MSB first
  // STOP    | sampling the stop bit and committing the packet
  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

  localparam int            GW       = $clog2(GAP_LIMIT + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LIMIT);

  state_t        state_q;
  logic          type_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    pay_q;
  logic [63:0]   data_q;
  logic [3:0]    cnt_q;
  logic [GW-1:0] gap_q;

  logic [63:0] data_d;
  logic [3:0]  cnt_d;
  logic [2:0]  err_d;
  logic        crc_bad;

  assign data_d = {data_q[55:0], pay_q};
  assign cnt_d  = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;

`ifdef ALU_SERIAL_RX_CRC_CHECK_EN
  // Serial x^4 + x + 1, zero seed, message consumed MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign crc_bad = (crc4({data_q, 1'b1, pay_q[6:4]}) != pay_q[3:0]);
`else
  assign crc_bad = 1'b0;
`endif

  // Only ops 000, 001, 100, 101 are legal, i.e. op[1] must be clear.
  always_comb begin
    err_d = 3'b000;
    if (cnt_q != 4'd8)  err_d = 3'b100;
    else if (crc_bad)   err_d = 3'b010;
    else if (pay_q[5])  err_d = 3'b001;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      type_q    <= 1'b0;
      bit_cnt_q <= 3'd0;
      pay_q     <= 8'd0;
      data_q    <= 64'd0;
      cnt_q     <= 4'd0;
      gap_q     <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      a_out     <= 32'd0;
      b_out     <= 32'd0;
      op_out    <= 3'd0;
      err_flags <= 3'd0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!sin) begin
            state_q <= TYPE;
            gap_q   <= GAP_LOAD;
          end else if (cnt_q != 4'd0) begin
            // gap_q reaches 1 on the GAP_LIMIT-th consecutive idle cycle
            if (gap_q == GW'(1)) begin
              cnt_q  <= 4'd0;
              data_q <= 64'd0;
            end else begin
              gap_q <= gap_q - GW'(1);
            end
          end
        end
        TYPE: begin
          type_q    <= sin;
          bit_cnt_q <= 3'd0;
          state_q   <= PAYLOAD;
        end
        PAYLOAD: begin
          pay_q     <= {pay_q[6:0], sin};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_q <= STOP;
        end
        STOP: begin
          state_q <= IDLE;
          if (!sin) begin
            frame_err <= 1'b1;
            cnt_q     <= 4'd0;
            data_q    <= 64'd0;
          end else if (!type_q) begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
          end else begin
            cmd_valid <= 1'b1;
            op_out    <= pay_q[6:4];
            err_flags <= err_d;
            if (cnt_q == 4'd8) begin
              a_out <= data_q[31:0];
              b_out <= data_q[63:32];
            end else begin
              a_out <= 32'd0;
              b_out <= 32'd0;
            end
            cnt_q  <= 4'd0;
            data_q <= 64'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Scoreboard bench for alu_serial_rx: directed frames push expectations, a monitor pops on cmd_valid.
module tb_alu_serial_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        cmd_valid;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [2:0]  op_out;
  logic [2:0]  err_flags;
  logic        frame_err;

  alu_serial_rx #(.GAP_LIMIT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .cmd_valid (cmd_valid),
    .a_out     (a_out),
    .b_out     (b_out),
    .op_out    (op_out),
    .err_flags (err_flags),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

`ifdef ALU_SERIAL_RX_CRC_CHECK_EN
  localparam logic [2:0] CRC_ERR = 3'b010;
`else
  localparam logic [2:0] CRC_ERR = 3'b000;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_valid  = 0;
  int   n_ferr   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Remainder of {msg, 0000} divided by x^4 + x + 1 (long division).
  function automatic logic [3:0] model_crc(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic expect_cmd(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [2:0] err);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    sin = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_pkt(input logic t, input logic [7:0] p, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(p[i]);
    send_bit(stop);
  endtask

  task automatic send_data(input logic [31:0] b, input logic [31:0] a, input int npkt,
                           input int gap_after, input int gap_len);
    logic [63:0] d;
    d = {b, a};
    for (int k = 0; k < npkt; k++) begin
      send_pkt(1'b0, d[63-8*k -: 8], 1'b1);
      if (k + 1 == gap_after) idle(gap_len);
    end
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc_x, input int gap_after, input int gap_len);
    send_data(b, a, 8, gap_after, gap_len);
    send_pkt(1'b1, {1'b0, op, model_crc(b, a, op) ^ crc_x}, 1'b1);
    idle(3);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_a_out"}, a_out, 32'd0);
    check({tag, "_b_out"}, b_out, 32'd0);
    check({tag, "_op_out"}, 32'(op_out), 32'd0);
    check({tag, "_err_flags"}, 32'(err_flags), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (frame_err) n_ferr++;
    if (cmd_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_cmd_valid: got a=0x%0h b=0x%0h op=%b err=%b, expected no cmd_valid",
                 a_out, b_out, op_out, err_flags);
      end else begin
        e = exp_q.pop_front();
        check("a_out", a_out, e.a);
        check("b_out", b_out, e.b);
        check("op_out", 32'(op_out), 32'(e.op));
        check("err_flags", 32'(err_flags), 32'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check_cleared("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Nominal frame
    expect_cmd(32'h5, 32'h3, 3'b100, 3'b000);
    send_frame(32'h3, 32'h5, 3'b100, 4'h0, 0, 0);

    // Corrupted CRC
    expect_cmd(32'h5, 32'h3, 3'b100, CRC_ERR);
    send_frame(32'h3, 32'h5, 3'b100, 4'h1, 0, 0);

    // Short frame: only two DATA packets
    expect_cmd(32'h0, 32'h0, 3'b000, 3'b100);
    send_pkt(1'b0, 8'h11, 1'b1);
    send_pkt(1'b0, 8'h22, 1'b1);
    send_pkt(1'b1, 8'h00, 1'b1);
    idle(3);

    // Illegal op with valid CRC
    expect_cmd(32'h9ABC_DEF0, 32'h1234_5678, 3'b010, 3'b001);
    send_frame(32'h1234_5678, 32'h9ABC_DEF0, 3'b010, 4'h0, 0, 0);

    // Bad stop bit on 5th DATA packet, then a clean frame
    send_data(32'hCAFE_F00D, 32'h0BAD_BEEF, 4, 0, 0);
    send_pkt(1'b0, 8'h77, 1'b0);
    idle(3);
    expect_cmd(32'h0102_0304, 32'hDEAD_BEEF, 3'b001, 3'b000);
    send_frame(32'hDEAD_BEEF, 32'h0102_0304, 3'b001, 4'h0, 0, 0);

    // Gap of GAP_LIMIT-1 idle cycles inside a frame is tolerated
    expect_cmd(32'h0000_000B, 32'h0000_00A0, 3'b101, 3'b000);
    send_frame(32'h0000_00A0, 32'h0000_000B, 3'b101, 4'h0, 4, 63);

    // Gap of GAP_LIMIT idle cycles drops the partial frame silently
    send_data(32'h5555_5555, 32'hAAAA_AAAA, 3, 0, 0);
    idle(64);
    expect_cmd(32'h9, 32'h7, 3'b000, 3'b000);
    send_frame(32'h7, 32'h9, 3'b000, 4'h0, 0, 0);

    // Reset after 6 DATA packets, then a full frame
    send_data(32'h1111_2222, 32'h3333_4444, 6, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_cmd(32'hFFFF_FFFF, 32'h1, 3'b101, 3'b000);
    send_frame(32'h1, 32'hFFFF_FFFF, 3'b101, 4'h0, 0, 0);

    idle(10);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    check("frame_err_pulses", 32'(n_ferr), 32'd1);
    check("cmd_valid_pulses", 32'(n_valid), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
